// File: rtl/cache_types_pkg.sv
// Shared types and sizing for the cache line <-> burst memory adapter.
package cache_types;

  localparam int ADDR_WIDTH       = 32;
  localparam int LINE_WIDTH       = 256;
  localparam int BEAT_WIDTH       = 64;
  localparam int BEATS            = LINE_WIDTH / BEAT_WIDTH;
  localparam int LINE_OFFSET_BITS = 5;
  localparam int LINE_ADDR_WIDTH  = ADDR_WIDTH - LINE_OFFSET_BITS;
  localparam int BEAT_CNT_WIDTH   = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_BURST,
    RESP
  } adapter_state_t;

  // Rebuild a full byte address from a line address (offset bits zeroed).
  function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [LINE_ADDR_WIDTH-1:0] line_addr);
    return {line_addr, {LINE_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Converts single 256-bit cache line reads/writes into 4-beat bursts on the
// burst memory port, and assembles returning read beats back into a line.
module cacheline_adapter
  import cache_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] dfp_addr,
  input  logic                  dfp_read,
  input  logic                  dfp_write,
  input  logic [LINE_WIDTH-1:0] dfp_wdata,
  output logic [LINE_WIDTH-1:0] dfp_rdata,
  output logic                  dfp_resp,
  output logic [ADDR_WIDTH-1:0] bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [ADDR_WIDTH-1:0] bmem_raddr,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_rvalid
);

  adapter_state_t                  state, state_next;
  logic [BEAT_CNT_WIDTH-1:0]       beat_cnt;
  logic [LINE_ADDR_WIDTH-1:0]      line_addr;
  // One buffer serves both directions: holds the write line during a burst,
  // or collects read beats. is_read selects whether RESP exposes it.
  logic [BEATS-1:0][BEAT_WIDTH-1:0] line_buf;
  logic                            is_read;
  logic                            beat_hit;
  logic                            unused_offset;

  // Line offset bits of the request address carry no information here.
  assign unused_offset = ^dfp_addr[LINE_OFFSET_BITS-1:0];

  // A returning beat only counts if it belongs to the line we asked for.
  assign beat_hit = bmem_rvalid && (bmem_raddr == line_base(line_addr));

  // State, beat counter and line/address capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      line_addr <= '0;
      line_buf  <= '0;
      is_read   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (dfp_write) begin
            line_addr <= dfp_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS];
            line_buf  <= dfp_wdata;
            beat_cnt  <= '0;
            is_read   <= 1'b0;
          end else if (dfp_read) begin
            line_addr <= dfp_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS];
            beat_cnt  <= '0;
            is_read   <= 1'b1;
          end
        end
        RD_REQ: begin
          if (bmem_ready) beat_cnt <= '0;
        end
        RD_WAIT: begin
          if (beat_hit) begin
            line_buf[beat_cnt] <= bmem_rdata;
            beat_cnt           <= beat_cnt + 1'b1;
          end
        end
        WR_BURST: begin
          if (bmem_ready) beat_cnt <= beat_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state selection and all port outputs; everything idles at zero.
  always_comb begin
    state_next = state;
    dfp_rdata  = '0;
    dfp_resp   = 1'b0;
    bmem_addr  = '0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = '0;
    case (state)
      IDLE: begin
        // Write wins if the cache ever raises both.
        if (dfp_write)     state_next = WR_BURST;
        else if (dfp_read) state_next = RD_REQ;
      end
      RD_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = line_base(line_addr);
        if (bmem_ready) state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (beat_hit && beat_cnt == BEAT_CNT_WIDTH'(BEATS-1)) state_next = RESP;
      end
      WR_BURST: begin
        bmem_write = 1'b1;
        bmem_addr  = line_base(line_addr);
        bmem_wdata = line_buf[beat_cnt];
        if (bmem_ready && beat_cnt == BEAT_CNT_WIDTH'(BEATS-1)) state_next = RESP;
      end
      RESP: begin
        // The cache still holds its request here; going straight to IDLE
        // without looking at dfp_read/dfp_write avoids re-accepting it.
        dfp_resp   = 1'b1;
        dfp_rdata  = is_read ? line_buf : '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: table-driven write and read line
// transactions plus hand-built reset, priority and write-back+fill sequences.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int tests = 0;
  int fails = 0;

  cacheline_adapter dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [31:0]  exp_addr;
    logic [15:0]  stall;     // bit c set: bmem_ready low in cycle c
    int           exp_resp;  // cycle of dfp_resp, request seen in cycle 0
  } wr_vec_t;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] line;
    logic [31:0]  exp_addr;
    int           gap;       // idle cycles before each beat
    int           req_stall; // cycles of bmem_ready low while requesting
    bit           stray;     // inject a wrong-address beat before beat 2
  } rd_vec_t;

  wr_vec_t wv[4];
  rd_vec_t rv[3];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    @(negedge clk);
    chk({nm, " ctl"}, {bmem_read, bmem_write, dfp_resp}, 3'b000);
    chk({nm, " addr"}, bmem_addr, 32'h0);
    next_cyc();
  endtask

  task automatic do_write(input string nm, input logic [31:0] addr, input logic [255:0] wd,
                          input logic [31:0] exp_addr, input logic [15:0] stall,
                          input int exp_resp, input bit tail);
    int beat = 0;
    dfp_write = 1'b1;
    dfp_addr  = addr;
    dfp_wdata = wd;
    for (int c = 0; c <= exp_resp; c++) begin
      bmem_ready = ~stall[c];
      @(negedge clk);
      if (c == 0) begin
        chk($sformatf("%s c0 ctl", nm), {bmem_read, bmem_write, dfp_resp}, 3'b000);
      end else if (c < exp_resp) begin
        chk($sformatf("%s c%0d ctl", nm, c), {bmem_read, bmem_write, dfp_resp}, 3'b010);
        chk($sformatf("%s c%0d addr", nm, c), bmem_addr, exp_addr);
        chk($sformatf("%s c%0d wdata", nm, c), bmem_wdata, wd[64*beat +: 64]);
        if (bmem_ready) beat++;
      end else begin
        chk($sformatf("%s resp ctl", nm), {bmem_read, bmem_write, dfp_resp}, 3'b001);
        chk($sformatf("%s resp rdata", nm), dfp_rdata, 256'h0);
        chk($sformatf("%s resp addr", nm), bmem_addr, 32'h0);
      end
      next_cyc();
    end
    dfp_write  = 1'b0;
    bmem_ready = 1'b1;
    if (tail) chk_idle({nm, " after"});
  endtask

  task automatic do_read(input string nm, input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [255:0] line, input int gap, input int req_stall,
                         input bit stray, input bit tail);
    dfp_read    = 1'b1;
    dfp_addr    = addr;
    bmem_ready  = 1'b1;
    bmem_rvalid = 1'b0;
    @(negedge clk);
    chk($sformatf("%s c0 ctl", nm), {bmem_read, bmem_write, dfp_resp}, 3'b000);
    next_cyc();
    // Matching beats offered while still requesting must be ignored.
    for (int s = 0; s <= req_stall; s++) begin
      bmem_ready  = (s == req_stall);
      bmem_rvalid = 1'b1;
      bmem_raddr  = exp_addr;
      bmem_rdata  = 64'hBAD0_BAD0_BAD0_0000 | 64'(s);
      @(negedge clk);
      chk($sformatf("%s req%0d ctl", nm, s), {bmem_read, bmem_write, dfp_resp}, 3'b100);
      chk($sformatf("%s req%0d addr", nm, s), bmem_addr, exp_addr);
      next_cyc();
    end
    bmem_ready  = 1'b1;
    bmem_rvalid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        bmem_rvalid = 1'b0;
        @(negedge clk);
        chk($sformatf("%s gap b%0d", nm, b), {bmem_read, bmem_write, dfp_resp}, 3'b000);
        next_cyc();
      end
      if (stray && b == 2) begin
        bmem_rvalid = 1'b1;
        bmem_raddr  = exp_addr + 32'h20;
        bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        chk($sformatf("%s stray", nm), {bmem_read, bmem_write, dfp_resp}, 3'b000);
        next_cyc();
      end
      bmem_rvalid = 1'b1;
      bmem_raddr  = exp_addr;
      bmem_rdata  = line[64*b +: 64];
      @(negedge clk);
      chk($sformatf("%s beat%0d ctl", nm, b), {bmem_read, bmem_write, dfp_resp}, 3'b000);
      next_cyc();
    end
    bmem_rvalid = 1'b0;
    bmem_rdata  = 64'h0;
    @(negedge clk);
    chk($sformatf("%s resp ctl", nm), {bmem_read, bmem_write, dfp_resp}, 3'b001);
    chk($sformatf("%s resp rdata", nm), dfp_rdata, line);
    next_cyc();
    dfp_read = 1'b0;
    if (tail) chk_idle({nm, " after"});
  endtask

  localparam logic [255:0] LINE_A = {64'hA3A3_3333_0000_00A3, 64'hA2A2_2222_0000_00A2,
                                     64'hA1A1_1111_0000_00A1, 64'hA0A0_0000_0000_00A0};
  localparam logic [255:0] LINE_B = {64'hB3B3_3333_0000_00B3, 64'hB2B2_2222_0000_00B2,
                                     64'hB1B1_1111_0000_00B1, 64'hB0B0_0000_0000_00B0};
  localparam logic [255:0] LINE_C = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000,
                                     64'h8000_0000_0000_0001, 64'h0123_4567_89AB_CDEF};
  localparam logic [255:0] LINE_D = {64'h0D0D_0D0D_0D0D_0D03, 64'h0D0D_0D0D_0D0D_0D02,
                                     64'h0D0D_0D0D_0D0D_0D01, 64'h0D0D_0D0D_0D0D_0D00};

  initial begin
    wv[0] = '{32'h0000_1234, LINE_A, 32'h0000_1220, 16'h0000, 5};
    wv[1] = '{32'h0000_1234, LINE_A, 32'h0000_1220, 16'h0004, 6};
    wv[2] = '{32'hFFFF_FFFF, LINE_C, 32'hFFFF_FFE0, 16'h0000, 5};
    wv[3] = '{32'h0000_001F, LINE_D, 32'h0000_0000, 16'h0012, 7};

    rv[0] = '{32'h8000_0040, LINE_B, 32'h8000_0040, 2, 0, 1'b0};
    rv[1] = '{32'h8000_0040, LINE_C, 32'h8000_0040, 2, 1, 1'b1};
    rv[2] = '{32'h1234_567F, LINE_D, 32'h1234_5660, 0, 2, 1'b1};

    rst = 1'b1;
    dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset ctl", {bmem_read, bmem_write, dfp_resp}, 3'b000);
    chk("reset rdata", dfp_rdata, 256'h0);
    chk("reset addr", bmem_addr, 32'h0);
    chk("reset wdata", bmem_wdata, 64'h0);
    next_cyc();
    rst = 1'b0;
    chk_idle("post reset");

    foreach (wv[i])
      do_write($sformatf("wr%0d", i), wv[i].addr, wv[i].wdata, wv[i].exp_addr,
               wv[i].stall, wv[i].exp_resp, 1'b1);

    foreach (rv[i])
      do_read($sformatf("rd%0d", i), rv[i].addr, rv[i].exp_addr, rv[i].line,
              rv[i].gap, rv[i].req_stall, rv[i].stray, 1'b1);

    // A write right after a read must report a zero line.
    do_write("wr after rd", 32'h0000_0100, LINE_B, 32'h0000_0100, 16'h0000, 5, 1'b1);

    // Both requests high: write wins, no read issued.
    dfp_read = 1'b1;
    do_write("prio", 32'h0000_2040, LINE_D, 32'h0000_2040, 16'h0000, 5, 1'b0);
    dfp_read = 1'b0;
    chk_idle("prio after");

    // Write-back then fill, back to back with no gap from the cache side.
    do_write("wb", 32'h4000_0080, LINE_C, 32'h4000_0080, 16'h0000, 5, 1'b0);
    do_read("fill", 32'h4000_00A0, 32'h4000_00A0, LINE_A, 1, 0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) chk_idle($sformatf("wbfill idle%0d", k));

    // Reset during beat 2 of a write burst.
    dfp_write = 1'b1; dfp_addr = 32'h0000_0040; dfp_wdata = LINE_B; bmem_ready = 1'b1;
    next_cyc(); next_cyc(); next_cyc();
    @(negedge clk);
    chk("rstmid before ctl", {bmem_read, bmem_write, dfp_resp}, 3'b010);
    chk("rstmid before wdata", bmem_wdata, LINE_B[191:128]);
    #1 rst = 1'b1;
    #1;
    chk("rstmid async ctl", {bmem_read, bmem_write, dfp_resp}, 3'b000);
    chk("rstmid async addr", bmem_addr, 32'h0);
    dfp_write = 1'b0;
    next_cyc();
    rst = 1'b0;
    // Late read beats after reset must be ignored.
    bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_0040; bmem_rdata = 64'h1111_2222_3333_4444;
    for (int k = 0; k < 4; k++) chk_idle($sformatf("rstmid late%0d", k));
    bmem_rvalid = 1'b0;
    chk_idle("rstmid quiet");
    do_write("after rst", 32'h0000_0040, LINE_A, 32'h0000_0040, 16'h0000, 5, 1'b1);

    // Reset mid read: partial line must not leak into a later read.
    dfp_read = 1'b1; dfp_addr = 32'h0000_0300; bmem_ready = 1'b1;
    next_cyc(); next_cyc();
    bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_0300; bmem_rdata = 64'hEEEE_EEEE_EEEE_EEEE;
    next_cyc();
    bmem_rvalid = 1'b0;
    #1 rst = 1'b1;
    #1;
    dfp_read = 1'b0;
    next_cyc();
    rst = 1'b0;
    chk_idle("rst rd idle");
    do_read("rd after rst", 32'h0000_0300, 32'h0000_0300, LINE_D, 0, 0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
